scan_shift_ctrl: RTL and testbench
==================================

// Module: scan_shift_ctrl
// PURPOSE
//  Parametrised scan/shift register with a sequenced scan controller. Gives software/JTAG-side
//  logic a WIDTH-bit serial access path (capture -> shift -> update) plus functional
//  shift/rotate/parallel-load ops. data_out is a shadow register, frozen while a scan is in
//  flight, so downstream logic never sees partially shifted data.
// PARAMETERS
//  WIDTH    16   register width in bits; legal range WIDTH >= 2
//  CNT_W    $clog2(WIDTH)   shift-counter width; derived localparam, not overridable
// PORTS
//  clk           in   1      clock, rising edge
//  reset         in   1      asynchronous, active-low reset
//  scan_start    in   1      request a scan sequence; sampled only in IDLE
//  scan_capture  in   1      sampled with scan_start; 1 = load capture_data before shifting
//  capture_data  in   WIDTH  parallel value captured into the chain
//  scan_abort    in   1      abandon an in-flight scan (CAPTURE/SHIFT only)
//  scan_in       in   1      serial input, shifted into bit 0
//  scan_out      out  1      serial output = shift_reg[WIDTH-1]
//  scan_busy     out  1      1 whenever state != IDLE
//  scan_done     out  1      one-cycle pulse; data_out holds the newly scanned value
//  load          in   1      functional parallel load (IDLE only)
//  load_data     in   WIDTH  value for load
//  enable        in   1      functional shift enable (IDLE only)
//  mode          in   2      00 shl fill 0, 01 shr fill 1, 10 rotl, 11 rotr
//  data_out      out  WIDTH  shadow/output register
// BEHAVIOUR
//  Reset (async, reset=0): shift_reg=0, data_out=0, counter=0, state=IDLE, scan_done=0.
//   Outputs: scan_out=0, scan_busy=0. Applies mid-operation and aborts any scan.
//  FSM: IDLE, CAPTURE, SHIFT, UPDATE.
//  IDLE, priority scan_start > load > enable:
//   scan_start=1 -> CAPTURE if scan_capture=1, else SHIFT. Counter cleared. load/enable that
//    cycle ignored.
//   load=1 -> shift_reg and data_out <= load_data.
//   enable=1 -> shift_reg and data_out <= op(shift_reg, mode).
//   Ops: 00 {r[W-2:0],0}; 01 {1,r[W-1:1]}; 10 {r[W-2:0],r[W-1]}; 11 {r[0],r[W-1:1]}.
//   Otherwise hold. In IDLE data_out == shift_reg at all times.
//  CAPTURE: one cycle. shift_reg <= capture_data -> SHIFT.
//  SHIFT: each edge shift_reg <= {shift_reg[W-2:0], scan_in}; counter++.
//   After the WIDTH-th shift edge (counter == WIDTH-1 on that edge) -> UPDATE.
//   Bits go out MSB first; the first scan_in bit ends at bit WIDTH-1.
//  UPDATE: one cycle. data_out <= shift_reg, scan_done <= 1 (registered) -> IDLE.
//   scan_done is high exactly in the first IDLE cycle after UPDATE.
//  Latency, scan_start edge to scan_done high: WIDTH+2 edges (no capture), WIDTH+3 (capture).
//  scan_abort in CAPTURE/SHIFT: next edge shift_reg <= data_out; state IDLE; no scan_done;
//   data_out unchanged. Ignored in IDLE and UPDATE (the update completes).
//  scan_start, load, enable, mode are ignored while busy. data_out is frozen from the
//   scan_start edge until the UPDATE edge.
//  scan_busy is combinational from state; scan_out is combinational from shift_reg.
// TESTING (WIDTH=8)
//  Reset mid-SHIFT (after 3 shifts) -> next cycle data_out=0x00, scan_busy=0, scan_out=0,
//   no scan_done; a following scan completes normally.
//  Functional ops: load 0xA5, then mode00+enable -> 0x4A, then mode01+enable -> 0xA5.
//   Load 0x81: mode10 -> 0x03; reload 0x81, mode11 -> 0xC0.
//  Capture scan: data_out=0x11, capture_data=0x3C, scan_in MSB-first 0xF0.
//   -> scan_out sequence in SHIFT = 0,0,1,1,1,1,0,0; data_out stays 0x11 while busy.
//   -> scan_done on the 11th edge after start, with data_out=0xF0.
//  Plain scan, no capture: start with shift_reg=0x5A, shift in 0x0F.
//   -> scan_out = 0,1,0,1,1,0,1,0; done after 10 edges; data_out=0x0F.
//  Abort after 3 shift edges, data_out=0x77 -> IDLE next edge; shift_reg=data_out=0x77;
//   scan_out=0; no done pulse.
//  Collisions: scan_start+load(0xFF) together in IDLE -> scan runs, load ignored.
//   scan_start/enable/load pulsed while busy -> no effect; exactly one scan_done.

Source files
------------

// File: rtl/scan_shift_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : scan_shift_ctrl
// Description : WIDTH-bit scan/shift register with a capture -> shift -> update
//               scan sequencer, functional shift/rotate/load operations and a
//               shadow output register that is frozen while a scan is running.
// Revision    : 1.0 - initial release
// ============================================================================
module scan_shift_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             scan_start,
  input  logic             scan_capture,
  input  logic [WIDTH-1:0] capture_data,
  input  logic             scan_abort,
  input  logic             scan_in,
  output logic             scan_out,
  output logic             scan_busy,
  output logic             scan_done,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             enable,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] data_out
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_SHIFT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CAPTURE = 2'd1,
    S_SHIFT   = 2'd2,
    S_UPDATE  = 2'd3
  } state_t;

  state_t           state_q,     state_d;
  logic [WIDTH-1:0] shift_reg_q, shift_reg_d;
  logic [WIDTH-1:0] data_out_q,  data_out_d;
  logic [CNT_W-1:0] cnt_q,       cnt_d;
  logic             scan_done_q, scan_done_d;
  logic [WIDTH-1:0] op_result;

  // Functional shift/rotate result for the selected mode
  always_comb begin
    op_result = shift_reg_q;
    case (mode)
      2'b00:   op_result = {shift_reg_q[WIDTH-2:0], 1'b0};
      2'b01:   op_result = {1'b1, shift_reg_q[WIDTH-1:1]};
      2'b10:   op_result = {shift_reg_q[WIDTH-2:0], shift_reg_q[WIDTH-1]};
      default: op_result = {shift_reg_q[0], shift_reg_q[WIDTH-1:1]};
    endcase
  end

  // Next-state and datapath update for the scan sequencer and functional ops
  always_comb begin
    state_d     = state_q;
    shift_reg_d = shift_reg_q;
    data_out_d  = data_out_q;
    cnt_d       = cnt_q;
    scan_done_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (scan_start) begin
          // A scan request wins over any functional op in the same cycle
          cnt_d   = '0;
          state_d = scan_capture ? S_CAPTURE : S_SHIFT;
        end else if (load) begin
          shift_reg_d = load_data;
          data_out_d  = load_data;
        end else if (enable) begin
          shift_reg_d = op_result;
          data_out_d  = op_result;
        end
      end
      S_CAPTURE: begin
        if (scan_abort) begin
          // Restore the chain from the untouched shadow so IDLE keeps them equal
          shift_reg_d = data_out_q;
          state_d     = S_IDLE;
        end else begin
          shift_reg_d = capture_data;
          state_d     = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (scan_abort) begin
          shift_reg_d = data_out_q;
          cnt_d       = '0;
          state_d     = S_IDLE;
        end else begin
          shift_reg_d = {shift_reg_q[WIDTH-2:0], scan_in};
          if (cnt_q == LAST_SHIFT) begin
            cnt_d   = '0;
            state_d = S_UPDATE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: begin
        // UPDATE: publish the scanned value; abort no longer applies here
        data_out_d  = shift_reg_q;
        scan_done_d = 1'b1;
        state_d     = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      shift_reg_q <= '0;
      data_out_q  <= '0;
      cnt_q       <= '0;
      scan_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_reg_q <= shift_reg_d;
      data_out_q  <= data_out_d;
      cnt_q       <= cnt_d;
      scan_done_q <= scan_done_d;
    end
  end

  assign scan_out  = shift_reg_q[WIDTH-1];
  assign scan_busy = (state_q != S_IDLE);
  assign scan_done = scan_done_q;
  assign data_out  = data_out_q;

endmodule
`default_nettype wire

// File: tb/tb_scan_shift_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_scan_shift_ctrl
// Description : Self-checking bench for scan_shift_ctrl (WIDTH=8): vector
//               table for functional ops, directed scan corner cases and a
//               randomized run against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_scan_shift_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         scan_start = 1'b0;
  logic         scan_capture = 1'b0;
  logic [W-1:0] capture_data = '0;
  logic         scan_abort = 1'b0;
  logic         scan_in = 1'b0;
  logic         scan_out;
  logic         scan_busy;
  logic         scan_done;
  logic         load = 1'b0;
  logic [W-1:0] load_data = '0;
  logic         enable = 1'b0;
  logic [1:0]   mode = 2'b00;
  logic [W-1:0] data_out;

  int n_checks = 0;
  int n_pass   = 0;

  scan_shift_ctrl #(.WIDTH(W)) dut (
    .clk          (clk),
    .reset        (reset),
    .scan_start   (scan_start),
    .scan_capture (scan_capture),
    .capture_data (capture_data),
    .scan_abort   (scan_abort),
    .scan_in      (scan_in),
    .scan_out     (scan_out),
    .scan_busy    (scan_busy),
    .scan_done    (scan_done),
    .load         (load),
    .load_data    (load_data),
    .enable       (enable),
    .mode         (mode),
    .data_out     (data_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    else n_pass++;
  endtask

  // one rising edge, then settle before sampling
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [W-1:0] v);
    load = 1'b1; load_data = v;
    tick();
    load = 1'b0;
  endtask

  typedef struct {
    logic         ld;
    logic [W-1:0] ld_data;
    logic         en;
    logic [1:0]   md;
    logic [W-1:0] exp;
  } vec_t;

  vec_t vecs[10];

  // behavioural model state for the random phase
  logic [W-1:0] m_sr, m_do;
  bit           m_cap, m_upd, m_done;
  int           m_left;

  function automatic logic [W-1:0] apply_op(input logic [W-1:0] r, input logic [1:0] md);
    case (md)
      2'b00:   return r << 1;
      2'b01:   return (r >> 1) | 8'h80;
      2'b10:   return (r << 1) | (r >> (W - 1));
      default: return (r >> 1) | (r << (W - 1));
    endcase
  endfunction

  task automatic model_edge();
    bit nd = 0;
    if (m_upd) begin
      m_do = m_sr; nd = 1; m_upd = 0;
    end else if (m_cap) begin
      if (scan_abort) begin m_sr = m_do; m_cap = 0; end
      else begin m_sr = capture_data; m_cap = 0; m_left = W; end
    end else if (m_left > 0) begin
      if (scan_abort) begin m_sr = m_do; m_left = 0; end
      else begin
        m_sr = (m_sr << 1) | W'(scan_in);
        m_left--;
        if (m_left == 0) m_upd = 1;
      end
    end else if (scan_start) begin
      if (scan_capture) m_cap = 1; else m_left = W;
    end else if (load) begin
      m_sr = load_data; m_do = load_data;
    end else if (enable) begin
      m_sr = apply_op(m_sr, mode); m_do = m_sr;
    end
    m_done = nd;
  endtask

  initial begin
    logic [W-1:0] pat;
    logic [W-1:0] cap;
    int           dones;

    // ---------------- reset state ----------------
    #12;
    check("rst data_out", 32'(data_out), 32'h0);
    check("rst scan_busy", 32'(scan_busy), 32'h0);
    check("rst scan_out", 32'(scan_out), 32'h0);
    check("rst scan_done", 32'(scan_done), 32'h0);
    @(negedge clk);
    reset = 1'b1;
    tick();

    // ---------------- functional op table ----------------
    vecs[0] = '{1'b1, 8'hA5, 1'b0, 2'b00, 8'hA5};
    vecs[1] = '{1'b0, 8'h00, 1'b1, 2'b00, 8'h4A};
    vecs[2] = '{1'b0, 8'h00, 1'b1, 2'b01, 8'hA5};
    vecs[3] = '{1'b1, 8'h81, 1'b0, 2'b00, 8'h81};
    vecs[4] = '{1'b0, 8'h00, 1'b1, 2'b10, 8'h03};
    vecs[5] = '{1'b1, 8'h81, 1'b0, 2'b00, 8'h81};
    vecs[6] = '{1'b0, 8'h00, 1'b1, 2'b11, 8'hC0};
    vecs[7] = '{1'b0, 8'h00, 1'b1, 2'b11, 8'h60};
    vecs[8] = '{1'b0, 8'h00, 1'b0, 2'b10, 8'h60};
    vecs[9] = '{1'b0, 8'h00, 1'b1, 2'b10, 8'hC0};
    for (int i = 0; i < 10; i++) begin
      load = vecs[i].ld; load_data = vecs[i].ld_data;
      enable = vecs[i].en; mode = vecs[i].md;
      tick();
      check($sformatf("op%0d data_out", i), 32'(data_out), 32'(vecs[i].exp));
      check($sformatf("op%0d scan_out", i), 32'(scan_out), 32'(vecs[i].exp[W-1]));
    end
    load = 1'b0; enable = 1'b0; mode = 2'b00;

    // ---------------- capture scan ----------------
    do_load(8'h11);
    cap = 8'h3C; pat = 8'hF0;
    capture_data = cap; scan_capture = 1'b1; scan_start = 1'b1;
    tick();                                   // edge 1 -> CAPTURE
    scan_start = 1'b0; scan_capture = 1'b0;
    check("cap busy", 32'(scan_busy), 32'h1);
    tick();                                   // edge 2 -> SHIFT
    capture_data = 8'h00;
    for (int i = 0; i < W; i++) begin
      check($sformatf("cap scan_out%0d", i), 32'(scan_out), 32'(cap[W-1-i]));
      check("cap data_out frozen", 32'(data_out), 32'h11);
      scan_in = pat[W-1-i];
      tick();                                 // edges 3..10
    end
    check("cap done early", 32'(scan_done), 32'h0);
    check("cap busy in update", 32'(scan_busy), 32'h1);
    tick();                                   // edge 11
    check("cap done", 32'(scan_done), 32'h1);
    check("cap data_out", 32'(data_out), 32'hF0);
    check("cap busy end", 32'(scan_busy), 32'h0);
    tick();
    check("cap done one cycle", 32'(scan_done), 32'h0);

    // ---------------- plain scan ----------------
    do_load(8'h5A);
    cap = 8'h5A; pat = 8'h0F;
    scan_start = 1'b1;
    tick();                                   // edge 1 -> SHIFT
    scan_start = 1'b0;
    for (int i = 0; i < W; i++) begin
      check($sformatf("plain scan_out%0d", i), 32'(scan_out), 32'(cap[W-1-i]));
      scan_in = pat[W-1-i];
      tick();                                 // edges 2..9
    end
    check("plain done early", 32'(scan_done), 32'h0);
    tick();                                   // edge 10
    check("plain done", 32'(scan_done), 32'h1);
    check("plain data_out", 32'(data_out), 32'h0F);

    // ---------------- abort ----------------
    do_load(8'h77);
    scan_start = 1'b1; scan_in = 1'b1;
    tick();
    scan_start = 1'b0;
    repeat (3) tick();
    scan_abort = 1'b1;
    tick();
    scan_abort = 1'b0;
    check("abort busy", 32'(scan_busy), 32'h0);
    check("abort data_out", 32'(data_out), 32'h77);
    check("abort scan_out", 32'(scan_out), 32'h0);
    check("abort no done", 32'(scan_done), 32'h0);
    enable = 1'b1; mode = 2'b10;              // rotl exposes the restored chain
    tick();
    enable = 1'b0;
    check("abort chain restored", 32'(data_out), 32'hEE);
    check("abort no late done", 32'(scan_done), 32'h0);

    // ---------------- async reset mid-SHIFT ----------------
    do_load(8'hFF);
    scan_start = 1'b1; scan_in = 1'b1;
    tick();
    scan_start = 1'b0;
    repeat (3) tick();
    #2 reset = 1'b0;
    #1;
    check("rstmid data_out", 32'(data_out), 32'h0);
    check("rstmid busy", 32'(scan_busy), 32'h0);
    check("rstmid scan_out", 32'(scan_out), 32'h0);
    @(negedge clk);
    reset = 1'b1;
    tick();
    check("rstmid no done", 32'(scan_done), 32'h0);
    check("rstmid idle", 32'(scan_busy), 32'h0);
    pat = 8'hA3;
    scan_start = 1'b1;
    tick();
    scan_start = 1'b0;
    for (int i = 0; i < W; i++) begin
      scan_in = pat[W-1-i];
      tick();
    end
    tick();
    check("rstmid rescan done", 32'(scan_done), 32'h1);
    check("rstmid rescan data", 32'(data_out), 32'hA3);

    // ---------------- collisions ----------------
    do_load(8'h00);
    pat = 8'h6C;
    scan_start = 1'b1; load = 1'b1; load_data = 8'hFF;
    tick();
    scan_start = 1'b0; load = 1'b0;
    check("coll load ignored", 32'(data_out), 32'h00);
    check("coll busy", 32'(scan_busy), 32'h1);
    dones = 0;
    for (int i = 0; i < W; i++) begin
      scan_in = pat[W-1-i];
      scan_start = (i == 2);
      enable = (i == 4);
      load = (i == 5);
      load_data = 8'hFF;
      tick();
      if (scan_done) dones++;
    end
    load = 1'b1; enable = 1'b1; scan_start = 1'b1;   // during UPDATE
    tick();
    if (scan_done) dones++;
    load = 1'b0; enable = 1'b0; scan_start = 1'b0;
    check("coll data_out", 32'(data_out), 32'h6C);
    repeat (12) begin
      tick();
      if (scan_done) dones++;
    end
    check("coll one done", 32'(dones), 32'd1);
    check("coll idle", 32'(scan_busy), 32'h0);

    // ---------------- randomized vs model ----------------
    #2 reset = 1'b0;
    #1;
    @(negedge clk);
    reset = 1'b1;
    m_sr = '0; m_do = '0; m_cap = 0; m_upd = 0; m_done = 0; m_left = 0;
    for (int c = 0; c < 3000; c++) begin
      scan_start   = ($urandom_range(0, 7) == 0);
      scan_capture = $urandom_range(0, 1);
      capture_data = W'($urandom);
      scan_abort   = ($urandom_range(0, 29) == 0);
      scan_in      = $urandom_range(0, 1);
      load         = ($urandom_range(0, 5) == 0);
      load_data    = W'($urandom);
      enable       = ($urandom_range(0, 2) == 0);
      mode         = 2'($urandom);
      @(posedge clk);
      model_edge();
      #1;
      check("rnd data_out", 32'(data_out), 32'(m_do));
      check("rnd scan_out", 32'(scan_out), 32'(m_sr[W-1]));
      check("rnd scan_busy", 32'(scan_busy), 32'(m_cap || m_upd || (m_left > 0)));
      check("rnd scan_done", 32'(scan_done), 32'(m_done));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
